// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with NUM_RD combinational read ports, one write-back port and
// a per-register pending-write scoreboard. Decode reads operands together
// with a busy flag, issue reserves destination registers (with back-pressure
// once a register's pending counter is full), and write-back retires them.
//
// Optional feature: define REGFILE_BYPASS_EN to forward write-back data (and
// the matching retire) to read ports in the same cycle. When it is undefined
// the read ports show stored contents and the stored counter only.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   i_rd_addr    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data    read data, port k at [k*DATA_W +: DATA_W]
//   o_rd_busy    port k's register has outstanding writes
//   i_wb_en      write-back valid
//   i_wb_addr    write-back destination
//   i_wb_data    write-back value
//   i_iss_en     issue request, reserve i_iss_addr
//   i_iss_addr   destination being reserved
//   o_iss_ready  issue may be accepted this cycle
//   i_flush      clear the whole scoreboard
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_RD      = 2,
  parameter int CNT_W       = 2,
  parameter int PROTECT_TOP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_iss_en,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  output logic                     o_iss_ready,
  input  logic                     i_flush
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] w_regs [DEPTH];
  logic [CNT_W-1:0]  w_cnt  [DEPTH];

  logic w_wb_same;   // write-back targets the register being issued
  logic w_top_wb;    // write-back targets the protected top register
  logic w_wb_store;  // write-back data actually lands in the array
  logic w_iss_ready;
  logic w_iss_acc;

  assign w_wb_same   = i_wb_en && (i_wb_addr == i_iss_addr);
  assign w_top_wb    = (PROTECT_TOP != 0) && (i_wb_addr == TOP_ADDR);
  assign w_wb_store  = i_wb_en && !w_top_wb;

  // A full counter can still take an issue when a write-back to the same
  // register frees a slot in the same cycle.
  assign w_iss_ready = (w_cnt[i_iss_addr] != CNT_MAX) || w_wb_same;
  assign w_iss_acc   = i_iss_en && w_iss_ready;
  assign o_iss_ready = w_iss_ready;

  genvar gi;

  // Storage and pending counter, one slice per register.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_reg
      localparam logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(gi);
      localparam logic [DATA_W-1:0] RST_VAL  = (gi == DEPTH - 1) ? '0 : DATA_W'(gi);

      logic [DATA_W-1:0] r_data;
      logic [CNT_W-1:0]  r_cnt;
      logic              w_iss_hit;
      logic              w_wb_hit;

      assign w_iss_hit = w_iss_acc && (i_iss_addr == REG_ADDR);
      assign w_wb_hit  = i_wb_en && (i_wb_addr == REG_ADDR);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= RST_VAL;
          r_cnt  <= '0;
        end else begin
          if (w_wb_store && w_wb_hit) begin
            r_data <= i_wb_data;
          end
          // Flush wins over both updates; issue and retire on the same
          // register cancel; a retire on an idle register saturates at 0.
          if (i_flush) begin
            r_cnt <= '0;
          end else if (w_iss_hit && !w_wb_hit) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_wb_hit && !w_iss_hit && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end

      assign w_regs[gi] = r_data;
      assign w_cnt[gi]  = r_cnt;
    end
  endgenerate

  // Read ports.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : gen_rd
      logic [ADDR_W-1:0] w_ra;
      logic [CNT_W-1:0]  w_ra_cnt;

      assign w_ra     = i_rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_ra_cnt = w_cnt[w_ra];

`ifdef REGFILE_BYPASS_EN
      logic w_fwd;
      logic w_retire;

      // Protected-top data never reaches storage, so it is not forwarded.
      assign w_fwd    = w_wb_store && (i_wb_addr == w_ra);
      // Last outstanding write retiring now, with no new reservation landing.
      assign w_retire = i_wb_en && (i_wb_addr == w_ra) &&
                        (w_ra_cnt == CNT_W'(1)) &&
                        !(w_iss_acc && (i_iss_addr == w_ra));

      assign o_rd_data[gi*DATA_W +: DATA_W] = w_fwd ? i_wb_data : w_regs[w_ra];
      assign o_rd_busy[gi]                  = (w_ra_cnt != '0) && !w_retire;
`else
      assign o_rd_data[gi*DATA_W +: DATA_W] = w_regs[w_ra];
      assign o_rd_busy[gi]                  = (w_ra_cnt != '0);
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        iss_en;
  logic [3:0]  iss_addr;
  logic        iss_ready;
  logic        flush;

  int checks = 0;
  int errors = 0;

  // Reference model: plain register values and integer pending counts.
  logic [31:0] m_reg [16];
  int          m_cnt [16];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_busy   (rd_busy),
    .i_wb_en     (wb_en),
    .i_wb_addr   (wb_addr),
    .i_wb_data   (wb_data),
    .i_iss_en    (iss_en),
    .i_iss_addr  (iss_addr),
    .o_iss_ready (iss_ready),
    .i_flush     (flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      m_reg[r] = (r == 15) ? 32'd0 : 32'(r);
      m_cnt[r] = 0;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model.
  task automatic cyc(input logic ie, input logic [3:0] ia,
                     input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic fl, input logic [3:0] r0, input logic [3:0] r1);
    logic        exp_rdy;
    logic        acc;
    logic [31:0] ed;
    logic        eb;
    logic [3:0]  ra;
    @(negedge clk);
    iss_en = ie; iss_addr = ia; wb_en = we; wb_addr = wa; wb_data = wd;
    flush = fl; rd_addr = {r1, r0};
    #1;
    exp_rdy = !((m_cnt[ia] == 3) && !(we && (wa == ia)));
    acc     = ie && exp_rdy;
    check("iss_ready", {63'd0, iss_ready}, {63'd0, exp_rdy});
    for (int k = 0; k < 2; k++) begin
      ra = (k == 0) ? r0 : r1;
      ed = m_reg[ra];
      eb = (m_cnt[ra] != 0);
`ifdef REGFILE_BYPASS_EN
      if (we && (wa == ra) && (wa != 4'd15)) ed = wd;
      if (we && (wa == ra) && (m_cnt[ra] == 1) && !(acc && (ia == ra))) eb = 1'b0;
`endif
      check($sformatf("rd_data%0d_r%0d", k, ra), {32'd0, rd_data[k*32 +: 32]}, {32'd0, ed});
      check($sformatf("rd_busy%0d_r%0d", k, ra), {63'd0, rd_busy[k]}, {63'd0, eb});
    end
    $display("cyc iss=%0b/%0d acc=%0b wb=%0b/%0d/%h fl=%0b rd=%0d,%0d",
             ie, ia, acc, we, wa, wd, fl, r0, r1);
    @(posedge clk);
    if (we && (wa != 4'd15)) m_reg[wa] = wd;
    if (fl) begin
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    end else if (!(acc && we && (ia == wa))) begin
      if (acc) m_cnt[ia]++;
      if (we && (m_cnt[wa] > 0)) m_cnt[wa]--;
    end
  endtask

  task automatic rd(input logic [3:0] r0, input logic [3:0] r1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, r0, r1);
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0; rd_addr = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset contents on every register via both ports.
    for (int r = 0; r < 16; r++) rd(4'(r), 4'(15 - r));

    // Write-back with a same-cycle read of the same register.
    cyc(1'b0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd3, 4'd3);
    rd(4'd3, 4'd3);

    // Fill reg 5, back-pressure, issue+wb cancel, then drain.
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd0);
    cyc(1'b1, 4'd5, 1'b1, 4'd5, 32'hA5A5_0005, 1'b0, 4'd5, 4'd5);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 1'b1, 4'd5, 32'h500 + 32'(i), 1'b0, 4'd5, 4'd1);
    rd(4'd5, 4'd5);

    // Protected top register.
    cyc(1'b1, 4'd15, 1'b0, 4'd0, 32'd0, 1'b0, 4'd15, 4'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd15, 32'h1234, 1'b0, 4'd15, 4'd15);
    rd(4'd15, 4'd15);

    // Flush combined with a data write.
    cyc(1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd2);
    cyc(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd2);
    cyc(1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0, 4'd7, 4'd2);
    cyc(1'b0, 4'd0, 1'b1, 4'd2, 32'h55, 1'b1, 4'd2, 4'd7);
    rd(4'd1, 4'd2);
    rd(4'd7, 4'd2);

    // Asynchronous reset between edges with reg 4 busy and modified.
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd4, 1'b0, 4'd0, 32'd0, 1'b0, 4'd4, 4'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd4, 32'h99, 1'b0, 4'd4, 4'd0);
    rd(4'd4, 4'd4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data", {32'd0, rd_data[31:0]}, 64'd4);
    check("async_rst_busy", {62'd0, rd_busy}, 64'd0);
    check("async_rst_ready", {63'd0, iss_ready}, 64'd1);
    $display("async reset applied mid-cycle");
    model_reset();
    #1 rst_n = 1'b1;
    rd(4'd4, 4'd15);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), rnd_addr(),
          1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
          1'($urandom_range(0, 31) == 0), rnd_addr(), rnd_addr());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
